// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential req/ack fetch into a small PC+word FIFO feeding decode.
// A redirect clears the FIFO. A request that is still outstanding at the redirect is completed and its word is dropped.
module fetch_queue #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    fq_entry_t [DEPTH-1:0] mem;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, proj;
    logic          discard;
    logic [31:0]   redirect_pc;
    logic          complete, push, pop;
    logic [31:0]   target;

    assign complete = imem_req && imem_ack;
    assign push     = complete && !discard && !flush;
    assign pop      = id_valid && id_ready && !flush;
    assign proj     = count + CW'(push) - CW'(pop);
    assign target   = {flush_pc[31:2], 2'b00};

    assign id_valid = (count != '0);
    assign id_instr = id_valid ? mem[rptr].instr : NOP;
    assign id_pc    = id_valid ? mem[rptr].pc    : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req    <= 1'b0;
            imem_addr   <= RESET_VECTOR;
            discard     <= 1'b0;
            redirect_pc <= RESET_VECTOR;
        end else if (imem_req && !imem_ack) begin
            // Outstanding request must be held; a redirect is parked until its ack.
            if (flush) begin
                discard     <= 1'b1;
                redirect_pc <= target;
            end
        end else begin
            imem_req <= !flush && (proj < CW'(DEPTH));
            if (flush)
                imem_addr <= target;
            else if (complete && discard)
                imem_addr <= redirect_pc;
            else if (complete)
                imem_addr <= imem_addr + 32'd4;
            if (complete)
                discard <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= proj;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{pc: imem_addr, instr: imem_rdata};
    end

    // Request gating should make an overflowing push impossible.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(push && !pop && count == CW'(DEPTH)));
    end
endmodule
